// File: rtl/control_sequencer_if.sv
// Strobe bundle between the hardwired control sequencer and the bus-based CPU datapath.
// The sequencer owns every strobe; the datapath side supplies the latched opcode, CON result and stop request.
interface control_sequencer_if;
   logic [4:0] opcode;
   logic       con_ff;
   logic       stop;

   logic PCout, ZHighout, ZLowout, MDRout, HIout, LOout, InPortout, Cout, BAout, R_out;
   logic MARin, MDRin, PCin, IRin, Yin, HIin, LOin, ZHighIn, ZLowIn, R_in, CONin, OutPortin;
   logic IncPC, Read, Write;
   logic GRA, GRB, GRC;
   logic [3:0] alu_op;
   logic run;
   logic illegal_op;

   modport master (
      input  opcode, con_ff, stop,
      output PCout, ZHighout, ZLowout, MDRout, HIout, LOout, InPortout, Cout, BAout, R_out,
      output MARin, MDRin, PCin, IRin, Yin, HIin, LOin, ZHighIn, ZLowIn, R_in, CONin, OutPortin,
      output IncPC, Read, Write, GRA, GRB, GRC, alu_op, run, illegal_op
   );

   modport slave (
      output opcode, con_ff, stop,
      input  PCout, ZHighout, ZLowout, MDRout, HIout, LOout, InPortout, Cout, BAout, R_out,
      input  MARin, MDRin, PCin, IRin, Yin, HIin, LOin, ZHighIn, ZLowIn, R_in, CONin, OutPortin,
      input  IncPC, Read, Write, GRA, GRB, GRC, alu_op, run, illegal_op
   );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired T-state control unit: fetch in T0-T2, opcode-specific execute in T3-T7, halt at boundaries.
// Strobes are a Moore decode of (state, opcode); con_ff gates the branch PC load in T6.
module control_sequencer (
   input  logic                       clk,
   input  logic                       clr,
   control_sequencer_if.master        bus,
   output logic [3:0]                 state_o
);
   typedef enum logic [3:0] {
      S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
   } state_t;

   localparam logic [4:0] OP_LD   = 5'b00000, OP_LDI  = 5'b00001, OP_ST   = 5'b00010,
                          OP_ADD  = 5'b00011, OP_SUB  = 5'b00100, OP_AND  = 5'b00101,
                          OP_OR   = 5'b00110, OP_ADDI = 5'b00111, OP_ANDI = 5'b01000,
                          OP_ORI  = 5'b01001, OP_BR   = 5'b01010, OP_JR   = 5'b01011,
                          OP_NOP  = 5'b01100, OP_HALT = 5'b01101;

   state_t     state_q, state_d, boundary_d;
   logic [4:0] op;
   logic       is_ldst, is_ld, is_st, is_ldi, is_alu, is_imm, is_br, is_jr, is_nop, is_halt, is_ill;
   logic [3:0] alu_sel;

   assign op      = bus.opcode;
   assign is_ld   = (op == OP_LD);
   assign is_st   = (op == OP_ST);
   assign is_ldi  = (op == OP_LDI);
   assign is_ldst = is_ld | is_st | is_ldi;
   assign is_alu  = (op == OP_ADD) | (op == OP_SUB) | (op == OP_AND) | (op == OP_OR);
   assign is_imm  = (op == OP_ADDI) | (op == OP_ANDI) | (op == OP_ORI);
   assign is_br   = (op == OP_BR);
   assign is_jr   = (op == OP_JR);
   assign is_nop  = (op == OP_NOP);
   assign is_halt = (op == OP_HALT);
   assign is_ill  = (op > OP_HALT);
   assign state_o = state_q;

   always_comb begin
      alu_sel = 4'd0;
      case (op)
         OP_SUB:          alu_sel = 4'd1;
         OP_AND, OP_ANDI: alu_sel = 4'd2;
         OP_OR,  OP_ORI:  alu_sel = 4'd3;
         default:         alu_sel = 4'd0;
      endcase
   end

   // stop is only honoured on the edge that ends an instruction's last state
   assign boundary_d = bus.stop ? S_HALT : S_T0;

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_RESET: state_d = S_T0;
         S_T0:    state_d = S_T1;
         S_T1:    state_d = S_T2;
         S_T2:    state_d = S_T3;
         S_T3: begin
            if (is_halt)                        state_d = S_HALT;
            else if (is_jr || is_nop || is_ill) state_d = boundary_d;
            else                                state_d = S_T4;
         end
         S_T4:    state_d = S_T5;
         S_T5:    state_d = (is_ldi || is_alu || is_imm) ? boundary_d : S_T6;
         S_T6:    state_d = is_br ? boundary_d : S_T7;
         S_T7:    state_d = boundary_d;
         S_HALT:  state_d = S_HALT;
         default: state_d = S_RESET;
      endcase
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) state_q <= S_RESET;
      else     state_q <= state_d;
   end

   always_comb begin
      {bus.PCout, bus.ZHighout, bus.ZLowout, bus.MDRout, bus.HIout, bus.LOout,
       bus.InPortout, bus.Cout, bus.BAout, bus.R_out} = '0;
      {bus.MARin, bus.MDRin, bus.PCin, bus.IRin, bus.Yin, bus.HIin, bus.LOin,
       bus.ZHighIn, bus.ZLowIn, bus.R_in, bus.CONin, bus.OutPortin} = '0;
      {bus.IncPC, bus.Read, bus.Write, bus.GRA, bus.GRB, bus.GRC} = '0;
      bus.alu_op     = 4'd0;
      bus.illegal_op = 1'b0;
      bus.run        = (state_q != S_RESET) && (state_q != S_HALT);
      case (state_q)
         S_T0: {bus.PCout, bus.MARin, bus.IncPC, bus.ZLowIn, bus.ZHighIn} = '1;
         S_T1: {bus.Read, bus.MDRin, bus.ZLowout, bus.PCin} = '1;
         S_T2: {bus.MDRout, bus.IRin} = '1;
         S_T3: begin
            if (is_ldst)               {bus.GRB, bus.BAout, bus.Yin} = '1;
            else if (is_alu || is_imm) {bus.GRB, bus.R_out, bus.Yin} = '1;
            else if (is_br)            {bus.GRA, bus.R_out, bus.CONin} = '1;
            else if (is_jr)            {bus.GRA, bus.R_out, bus.PCin} = '1;
            bus.illegal_op = is_ill;
         end
         S_T4: begin
            if (is_ldst)     {bus.Cout, bus.ZLowIn, bus.ZHighIn} = '1;
            else if (is_alu) {bus.GRC, bus.R_out, bus.ZLowIn, bus.ZHighIn} = '1;
            else if (is_imm) {bus.Cout, bus.ZLowIn, bus.ZHighIn} = '1;
            else if (is_br)  {bus.PCout, bus.Yin} = '1;
            if (is_alu || is_imm) bus.alu_op = alu_sel;
         end
         S_T5: begin
            if (is_ld || is_st)                 {bus.ZLowout, bus.MARin} = '1;
            else if (is_ldi || is_alu || is_imm) {bus.ZLowout, bus.GRA, bus.R_in} = '1;
            else if (is_br)                     {bus.Cout, bus.ZLowIn, bus.ZHighIn} = '1;
         end
         S_T6: begin
            if (is_ld)                   {bus.Read, bus.MDRin} = '1;
            else if (is_st)              {bus.GRA, bus.R_out, bus.MDRin} = '1;
            else if (is_br && bus.con_ff) {bus.ZLowout, bus.PCin} = '1;
         end
         S_T7: begin
            if (is_ld)      {bus.MDRout, bus.GRA, bus.R_in} = '1;
            else if (is_st) bus.Write = 1'b1;
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench: per-instruction table of expected strobe words, plus hand sequences for halt, stop and async clear.
module tb_control_sequencer;
   logic       clk;
   logic       clr;
   logic [3:0] state_dbg;
   int         n_checks = 0;
   int         n_err    = 0;

   control_sequencer_if bif();

   control_sequencer dut (
      .clk     (clk),
      .clr     (clr),
      .bus     (bif),
      .state_o (state_dbg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   localparam logic [33:0] PCOUT = 34'(1) << 0,  ZHOUT = 34'(1) << 1,  ZLOUT = 34'(1) << 2,
                           MDROUT = 34'(1) << 3, HIOUT = 34'(1) << 4,  LOOUT = 34'(1) << 5,
                           INPOUT = 34'(1) << 6, COUT  = 34'(1) << 7,  BAOUT = 34'(1) << 8,
                           ROUT  = 34'(1) << 9,  MARIN = 34'(1) << 10, MDRIN = 34'(1) << 11,
                           PCIN  = 34'(1) << 12, IRIN  = 34'(1) << 13, YIN   = 34'(1) << 14,
                           HIIN  = 34'(1) << 15, LOIN  = 34'(1) << 16, ZHIN  = 34'(1) << 17,
                           ZLIN  = 34'(1) << 18, RIN   = 34'(1) << 19, CONIN = 34'(1) << 20,
                           OUTPIN = 34'(1) << 21, INCPC = 34'(1) << 22, READ  = 34'(1) << 23,
                           WRITE = 34'(1) << 24, GRA   = 34'(1) << 25, GRB   = 34'(1) << 26,
                           GRC   = 34'(1) << 27, A1    = 34'(1) << 28, A2    = 34'(2) << 28,
                           A3    = 34'(3) << 28, RUN   = 34'(1) << 32, ILL   = 34'(1) << 33;

   localparam logic [33:0] F0 = RUN | PCOUT | MARIN | INCPC | ZLIN | ZHIN;
   localparam logic [33:0] F1 = RUN | READ | MDRIN | ZLOUT | PCIN;
   localparam logic [33:0] F2 = RUN | MDROUT | IRIN;
   localparam logic [4:0]  JUNK = 5'h1F;

   typedef struct {
      logic [4:0]  op;
      logic        con;
      int          len;
      logic [33:0] e3, e4, e5, e6, e7;
      string       nm;
   } vec_t;

   vec_t tbl[16];

   function automatic logic [33:0] pack_outs();
      return {bif.illegal_op, bif.run, bif.alu_op, bif.GRC, bif.GRB, bif.GRA,
              bif.Write, bif.Read, bif.IncPC,
              bif.OutPortin, bif.CONin, bif.R_in, bif.ZLowIn, bif.ZHighIn, bif.LOin,
              bif.HIin, bif.Yin, bif.IRin, bif.PCin, bif.MDRin, bif.MARin,
              bif.R_out, bif.BAout, bif.Cout, bif.InPortout, bif.LOout, bif.HIout,
              bif.MDRout, bif.ZLowout, bif.ZHighout, bif.PCout};
   endfunction

   task automatic check(input logic [33:0] got, input logic [33:0] exp, input string nm);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   task automatic cyc(input logic [4:0] op, input logic c, input logic s,
                      input logic [33:0] exp, input string nm);
      @(negedge clk);
      bif.opcode = op;
      bif.con_ff = c;
      bif.stop   = s;
      #1 check(pack_outs(), exp, nm);
   endtask

   task automatic do_reset(input string nm);
      @(negedge clk);
      bif.opcode = JUNK;
      bif.con_ff = 1'b0;
      bif.stop   = 1'b0;
      clr = 1'b1;
      #1 check(pack_outs(), 34'd0, nm);
      clr = 1'b0;
   endtask

   task automatic fetch(input string nm);
      cyc(JUNK, 1'b0, 1'b0, F0, {nm, "_t0"});
      cyc(JUNK, 1'b0, 1'b0, F1, {nm, "_t1"});
      cyc(JUNK, 1'b0, 1'b0, F2, {nm, "_t2"});
   endtask

   initial begin
      logic [33:0] ex[5];

      tbl[0]  = '{5'b00000, 1'b0, 8, RUN|GRB|BAOUT|YIN, RUN|COUT|ZLIN|ZHIN, RUN|ZLOUT|MARIN,
                  RUN|READ|MDRIN, RUN|MDROUT|GRA|RIN, "ld"};
      tbl[1]  = '{5'b00001, 1'b0, 6, RUN|GRB|BAOUT|YIN, RUN|COUT|ZLIN|ZHIN, RUN|ZLOUT|GRA|RIN,
                  34'd0, 34'd0, "ldi"};
      tbl[2]  = '{5'b00010, 1'b1, 8, RUN|GRB|BAOUT|YIN, RUN|COUT|ZLIN|ZHIN, RUN|ZLOUT|MARIN,
                  RUN|GRA|ROUT|MDRIN, RUN|WRITE, "st"};
      tbl[3]  = '{5'b00011, 1'b0, 6, RUN|GRB|ROUT|YIN, RUN|GRC|ROUT|ZLIN|ZHIN, RUN|ZLOUT|GRA|RIN,
                  34'd0, 34'd0, "add"};
      tbl[4]  = '{5'b00100, 1'b0, 6, RUN|GRB|ROUT|YIN, RUN|GRC|ROUT|ZLIN|ZHIN|A1, RUN|ZLOUT|GRA|RIN,
                  34'd0, 34'd0, "sub"};
      tbl[5]  = '{5'b00101, 1'b0, 6, RUN|GRB|ROUT|YIN, RUN|GRC|ROUT|ZLIN|ZHIN|A2, RUN|ZLOUT|GRA|RIN,
                  34'd0, 34'd0, "and"};
      tbl[6]  = '{5'b00110, 1'b0, 6, RUN|GRB|ROUT|YIN, RUN|GRC|ROUT|ZLIN|ZHIN|A3, RUN|ZLOUT|GRA|RIN,
                  34'd0, 34'd0, "or"};
      tbl[7]  = '{5'b00111, 1'b0, 6, RUN|GRB|ROUT|YIN, RUN|COUT|ZLIN|ZHIN, RUN|ZLOUT|GRA|RIN,
                  34'd0, 34'd0, "addi"};
      tbl[8]  = '{5'b01000, 1'b0, 6, RUN|GRB|ROUT|YIN, RUN|COUT|ZLIN|ZHIN|A2, RUN|ZLOUT|GRA|RIN,
                  34'd0, 34'd0, "andi"};
      tbl[9]  = '{5'b01001, 1'b0, 6, RUN|GRB|ROUT|YIN, RUN|COUT|ZLIN|ZHIN|A3, RUN|ZLOUT|GRA|RIN,
                  34'd0, 34'd0, "ori"};
      tbl[10] = '{5'b01010, 1'b0, 7, RUN|GRA|ROUT|CONIN, RUN|PCOUT|YIN, RUN|COUT|ZLIN|ZHIN,
                  RUN, 34'd0, "br_nt"};
      tbl[11] = '{5'b01010, 1'b1, 7, RUN|GRA|ROUT|CONIN, RUN|PCOUT|YIN, RUN|COUT|ZLIN|ZHIN,
                  RUN|ZLOUT|PCIN, 34'd0, "br_t"};
      tbl[12] = '{5'b01011, 1'b0, 4, RUN|GRA|ROUT|PCIN, 34'd0, 34'd0, 34'd0, 34'd0, "jr"};
      tbl[13] = '{5'b01100, 1'b0, 4, RUN, 34'd0, 34'd0, 34'd0, 34'd0, "nop"};
      tbl[14] = '{5'b11111, 1'b0, 4, RUN|ILL, 34'd0, 34'd0, 34'd0, 34'd0, "ill_1f"};
      tbl[15] = '{5'b01110, 1'b1, 4, RUN|ILL, 34'd0, 34'd0, 34'd0, 34'd0, "ill_0e"};

      clr        = 1'b0;
      bif.opcode = 5'd0;
      bif.con_ff = 1'b0;
      bif.stop   = 1'b0;

      // Back-to-back instructions; each fetch also proves the previous one returned to T0.
      do_reset("reset_state");
      foreach (tbl[i]) begin
         ex = '{tbl[i].e3, tbl[i].e4, tbl[i].e5, tbl[i].e6, tbl[i].e7};
         fetch(tbl[i].nm);
         for (int k = 0; k < tbl[i].len - 3; k++)
            cyc(tbl[i].op, tbl[i].con, 1'b0, ex[k], $sformatf("%s_t%0d", tbl[i].nm, k + 3));
      end
      cyc(JUNK, 1'b0, 1'b0, F0, "return_t0");

      // halt opcode: T3 still running, then parked until clr
      do_reset("reset_halt");
      fetch("halt");
      cyc(5'b01101, 1'b0, 1'b0, RUN, "halt_t3");
      for (int k = 0; k < 20; k++)
         cyc(5'(k), 1'b0, 1'b0, 34'd0, $sformatf("halt_hold%0d", k));

      // stop raised mid-add is only honoured at the boundary after T5
      do_reset("reset_stop");
      fetch("stop_add");
      cyc(5'b00011, 1'b0, 1'b0, RUN|GRB|ROUT|YIN, "stop_add_t3");
      cyc(5'b00011, 1'b0, 1'b1, RUN|GRC|ROUT|ZLIN|ZHIN, "stop_add_t4");
      cyc(5'b00011, 1'b0, 1'b1, RUN|ZLOUT|GRA|RIN, "stop_add_t5");
      for (int k = 0; k < 20; k++)
         cyc(JUNK, 1'b0, 1'b0, 34'd0, $sformatf("stop_hold%0d", k));

      // stop together with halt opcode
      do_reset("reset_stop_halt");
      fetch("stop_halt");
      cyc(5'b01101, 1'b0, 1'b1, RUN, "stop_halt_t3");
      cyc(JUNK, 1'b0, 1'b0, 34'd0, "stop_halt_hold");

      // asynchronous clear in the middle of ld T6
      do_reset("reset_clr");
      fetch("clr_ld");
      cyc(5'b00000, 1'b0, 1'b0, RUN|GRB|BAOUT|YIN, "clr_ld_t3");
      cyc(5'b00000, 1'b0, 1'b0, RUN|COUT|ZLIN|ZHIN, "clr_ld_t4");
      cyc(5'b00000, 1'b0, 1'b0, RUN|ZLOUT|MARIN, "clr_ld_t5");
      cyc(5'b00000, 1'b0, 1'b0, RUN|READ|MDRIN, "clr_ld_t6");
      #1 clr = 1'b1;
      #1 check(pack_outs(), 34'd0, "clr_async");
      @(negedge clk);
      #1 check(pack_outs(), 34'd0, "clr_held");
      clr = 1'b0;
      cyc(JUNK, 1'b0, 1'b0, F0, "after_clr_t0");
      cyc(JUNK, 1'b0, 1'b0, F1, "after_clr_t1");

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule

// File: doc/control_sequencer.md
# control_sequencer

Hardwired control unit for the bus-based CPU datapath (CPUproject). It steps a T-state counter through fetch (T0–T2) and opcode-specific execute states, driving every datapath strobe (register-file select, bus-source enables, register load enables, memory read/write and ALU operation) so that no hand-written stimulus sequence is needed. It sits beside the datapath and takes only the latched opcode and the CON flip-flop result back from it.

## Interface
- No parameters; widths are fixed by the datapath.
- clk  in  1  system clock; all state changes on rising edge
- clr  in  1  reset, asynchronous, active-high
- opcode  in  5  IR[31:27]; valid from T3 onward
- con_ff  in  1  CON flip-flop output (branch taken)
- stop  in  1  level request to halt at the next instruction boundary
- PCout, ZHighout, ZLowout, MDRout, HIout, LOout, InPortout, Cout, BAout, R_out  out  1 each  bus-source enables
- MARin, MDRin, PCin, IRin, Yin, HIin, LOin, ZHighIn, ZLowIn, R_in, CONin, OutPortin  out  1 each  register load enables
- IncPC, Read, Write  out  1 each  PC increment, MDR-from-memory select, RAM write
- GRA, GRB, GRC  out  1 each  select-and-encode field selects
- alu_op  out  4  0=ADD, 1=SUB, 2=AND, 3=OR
- run  out  1  high while executing; low in HALT
- illegal_op  out  1  one-cycle pulse on undefined opcode

## Operation
- States: RESET, T0–T7, HALT. Each state lasts exactly one clock. All outputs are a Moore decode of (state, opcode). Only the listed strobes are high in each state; all others are 0. alu_op is 0 unless stated.
- Fetch for all opcodes: T0 PCout MARin IncPC ZLowIn ZHighIn; T1 Read MDRin ZLowout PCin; T2 MDRout IRin.
- Opcodes: ld=00000, ldi=00001, st=00010, add=00011, sub=00100, and=00101, or=00110, addi=00111, andi=01000, ori=01001, br=01010, jr=01011, nop=01100, halt=01101. Every other code is illegal.
- ld: T3 GRB BAout Yin; T4 Cout ZLowIn ZHighIn (ADD); T5 ZLowout MARin; T6 Read MDRin; T7 MDRout GRA R_in.
- ldi: T3 GRB BAout Yin; T4 Cout ZLowIn ZHighIn (ADD); T5 ZLowout GRA R_in.
- st: T3–T5 same as ld; T6 GRA R_out MDRin (Read=0); T7 Write.
- add/sub/and/or: T3 GRB R_out Yin; T4 GRC R_out ZLowIn ZHighIn, alu_op=0/1/2/3; T5 ZLowout GRA R_in.
- addi/andi/ori: T3 GRB R_out Yin; T4 Cout ZLowIn ZHighIn, alu_op=0/2/3; T5 ZLowout GRA R_in.
- br: T3 GRA R_out CONin; T4 PCout Yin; T5 Cout ZLowIn ZHighIn (ADD); T6 ZLowout PCin only if con_ff=1, otherwise no strobes.
- jr: T3 GRA R_out PCin.
- nop: T3 with no strobes. illegal: T3 with no strobes and illegal_op=1.
- halt: T3 with no strobes, then HALT.
- The last state of each instruction is followed by T0. The last states are: ld/st T7, br T6, ldi/ALU T5, jr/nop/illegal T3.
- Stop check: if stop=1 at the rising edge ending an instruction's last state, the next state is HALT instead of T0.
- HALT: all strobes 0, run=0. It is left only through clr.

## Timing
- clr=1 forces RESET immediately, without waiting for a clock. This also applies mid-instruction. In RESET every output is 0, including run and illegal_op.
- After clr deasserts, the first rising edge moves to T0, and run=1 from T0 onward.
- Instruction lengths in clocks, counted from T0: ld 8, st 8, br 7, ldi/ALU/ALU-imm 6, jr/nop/illegal/halt 4, plus HALT for halt.
- opcode is sampled only in T3–T7. It is ignored in T0–T2, and its value during fetch has no effect.
- con_ff is sampled combinationally in T6 of br. CONin in T3 loads CON at the end of T3.
- stop is ignored except at instruction boundaries. stop together with a halt opcode gives HALT, the same as halt alone.

## Test plan
- clr pulse, then 0x00800007 (ld r1,7) on memory -> T0..T7 strobes exactly as listed, R_in in the 8th cycle after T0, next cycle T0.
- Fetch 0x18000000-class add (opcode 00011) -> alu_op=0 with GRC R_out in T4, GRA R_in in T5, back to T0 after 6 cycles; repeat for sub -> alu_op=1.
- br with con_ff=0 then con_ff=1 -> PCin=0 in T6 for the first, PCin=1 with ZLowout for the second; both return to T0 after 7 cycles.
- opcode 11111 -> illegal_op=1 only during T3, no other strobes, T0 next.
- halt opcode, and separately stop=1 during T4 of an add -> run=0 after T3 (halt) / after T5 (add), all strobes 0, remaining in HALT for 20 clocks until clr.
- clr asserted mid-T6 of ld, between clock edges -> all outputs 0 before the next edge; after release, T0 on the first edge.
